// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Purpose  : AES forward S-box (SubBytes) for one byte. It gives a purely
//            combinational lookup and a registered copy of that lookup.
//            The substitution is computed with GF(2^8) arithmetic: the
//            inverse is x^254 modulo 0x11B, followed by the affine map.
// Ports    : clk   - clock; out_q updates on the rising edge
//            rst   - asynchronous reset, active low; clears out_q
//            in    - byte to substitute
//            out   - S(in), combinational, independent of clk/rst
//            out_q - S(in) registered on the rising edge of clk
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic [7:0] out_q
);

  localparam logic [7:0] c_POLY_LOW     = 8'h1B;  // x^8 folded back: x^4+x^3+x+1
  localparam logic [7:0] c_AFFINE_CONST = 8'h63;

  // Shift-and-add multiply, reducing after every shift so the running
  // partial product never leaves 8 bits.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? c_POLY_LOW : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128. Since 0^254 = 0, the zero input maps
  // to zero without a special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Each output bit i is b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7), all
  // indices mod 8. That equals b XOR its left rotations by 1 to 4.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b
         ^ {b[6:0], b[7]}
         ^ {b[5:0], b[7:6]}
         ^ {b[4:0], b[7:5]}
         ^ {b[3:0], b[7:4]}
         ^ c_AFFINE_CONST;
  endfunction

  logic [7:0] w_inv;
  logic [7:0] w_sbox;
  logic [7:0] r_out_q;

  always_comb begin
    w_inv  = gf_inv(in);
    w_sbox = affine(w_inv);
  end

  assign out = w_sbox;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_q <= 8'h00;
    end else begin
      r_out_q <= w_sbox;
    end
  end

  assign out_q = r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_sbox
// Purpose  : Self-checking bench for aes_sbox. The reference S-box is built
//            from first principles: carry-less product with long-division
//            reduction, inverse found by search, and the affine map applied
//            bit by bit.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_sbox;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic [7:0] out;
  logic [7:0] out_q;

  logic [31:0] word_in;
  logic [31:0] word_rot;
  logic [31:0] word_out;
  logic [31:0] word_q;

  int n_cmp;
  int n_fail;

  logic [7:0] ref_tab [256];

  aes_sbox dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .out   (out),
    .out_q (out_q)
  );

  // Four parallel lookups on a RotWord-ordered 32-bit word.
  assign word_rot = {word_in[23:0], word_in[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_word
      aes_sbox u_sb (
        .clk   (clk),
        .rst   (rst),
        .in    (word_rot[8*g +: 8]),
        .out   (word_out[8*g +: 8]),
        .out_q (word_q[8*g +: 8])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full polynomial product, then reduce modulo 0x11B by long division.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
             inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 0;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] din;
    logic [7:0] dexp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit   seen [256];
    int   distinct;
    int   fixed_pts;
    int   anti_pts;
    logic [7:0] rnd;

    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{8'h00, 8'h63};
    vecs[1] = '{8'h01, 8'h7C};
    vecs[2] = '{8'h09, 8'h01};
    vecs[3] = '{8'h10, 8'hCA};
    vecs[4] = '{8'h20, 8'hB7};
    vecs[5] = '{8'h53, 8'hED};
    vecs[6] = '{8'hC9, 8'hDD};
    vecs[7] = '{8'hFF, 8'h16};

    for (int i = 0; i < 256; i++) ref_tab[i] = ref_sbox(8'(i));

    rst     = 1'b0;
    in      = 8'h53;
    word_in = 32'h0000_0000;

    // Reset held with the clock running: the register stays clear, the
    // lookup keeps working.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("reset_out_q", 32'(out_q), 32'h00);
      check("reset_out", 32'(out), 32'hED);
    end

    // Known-answer table.
    for (int i = 0; i < 8; i++) begin
      in = vecs[i].din; #1;
      check($sformatf("kat_%02h", vecs[i].din), 32'(out), 32'(vecs[i].dexp));
    end

    // Exhaustive sweep against the reference and permutation properties.
    distinct = 0; fixed_pts = 0; anti_pts = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in = 8'(i); #1;
      check($sformatf("sweep_%02h", i), 32'(out), 32'(ref_tab[i]));
      if (!seen[out]) distinct++;
      seen[out] = 1'b1;
      if (out == 8'(i))  fixed_pts++;
      if (out == ~8'(i)) anti_pts++;
    end
    check("distinct_outputs", 32'(distinct), 32'd256);
    check("fixed_points", 32'(fixed_pts), 32'd0);
    check("anti_fixed_points", 32'(anti_pts), 32'd0);
    check("sweep_out_q_in_reset", 32'(out_q), 32'h00);

    // Release reset away from any rising edge, then one-cycle latency.
    @(negedge clk);
    rst = 1'b1;
    in  = 8'h01;
    @(posedge clk); #1;
    check("first_load", 32'(out_q), 32'h7C);
    @(negedge clk);
    in = 8'h10; #1;
    check("mid_cycle_out", 32'(out), 32'hCA);
    check("mid_cycle_out_q_hold", 32'(out_q), 32'h7C);
    @(posedge clk); #1;
    check("second_load", 32'(out_q), 32'hCA);

    // Streaming: each result appears one edge after its input.
    @(negedge clk); in = 8'h09;
    @(posedge clk); #1; check("stream_09", 32'(out_q), 32'h01);
    @(negedge clk); in = 8'h20;
    @(posedge clk); #1; check("stream_20", 32'(out_q), 32'hB7);
    @(negedge clk); in = 8'hC9;
    @(posedge clk); #1; check("stream_C9", 32'(out_q), 32'hDD);

    // Asynchronous reset pulse between edges.
    #2 rst = 1'b0;
    #1;
    check("async_clear", 32'(out_q), 32'h00);
    check("async_out_tracks", 32'(out), 32'hDD);
    in = 8'h53; #1;
    check("async_out_follows_in", 32'(out), 32'hED);
    check("async_held", 32'(out_q), 32'h00);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("reload_after_reset", 32'(out_q), 32'hED);

    // Randomised streaming against the reference table.
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      rnd = 8'($urandom_range(0, 255));
      in  = rnd; #1;
      check("rand_out", 32'(out), 32'(ref_tab[rnd]));
      @(posedge clk); #1;
      check("rand_out_q", 32'(out_q), 32'(ref_tab[rnd]));
    end

    // Four-byte word path: SubWord(RotWord(0)) and the rcon-adjusted word.
    word_in = 32'h0000_0000; #1;
    check("subword_zero", word_out, 32'h6363_6363);
    check("subword_rcon", word_out ^ 32'h0100_0000, 32'h6263_6363);
    word_in = 32'h0953_10FF; #1;
    check("subword_rot", word_out, {ref_tab[8'h53], ref_tab[8'h10], ref_tab[8'hFF], ref_tab[8'h09]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_sbox.md
Name: aes_sbox

Overview:
- AES forward substitution box (FIPS-197 SubBytes) for one byte.
- Purely combinational lookup path `out`, consumed the same cycle by the key-expansion block; four instances per 32-bit word (RotWord/SubWord).
- Additionally provides a registered copy `out_q` for pipelined users; this is the only state in the block.

Parameters:
- none

Ports:
- clk    input   1  clock; `out_q` updates on rising edge
- rst    input   1  asynchronous, active-low reset (asserted when 0); clears `out_q`
- in     input   8  byte to substitute
- out    output  8  S(in), combinational, no clock dependency
- out_q  output  8  S(in) registered on clk rising edge

Behaviour:
- S(x) definition:
  - Take the multiplicative inverse of x in GF(2^8), modulo x^8+x^4+x^3+x+1 (0x11B); inverse of 0x00 is 0x00.
  - Apply the affine transform b'_i = b_i ^ b_(i+4)%8 ^ b_(i+5)%8 ^ b_(i+6)%8 ^ b_(i+7)%8 ^ c_i, with c = 0x63.
- Implementation form:
  - Either a full 256-entry constant case table or equivalent GF logic.
  - Result must be bit-identical to the FIPS-197 table for all 256 inputs.
  - No latches: every input value covered, default arm present.
- `out` timing and reset independence:
  - Combinational; follows `in` within the same delta/cycle.
  - Independent of clk and rst; valid even while rst is low.
  - No X propagation for any known input.
- `out_q`:
  - rst low → `out_q` = 8'h00 immediately, without waiting for a clock edge.
  - Held at 0 while rst is low.
  - First rising edge with rst high → `out_q` = S(in) sampled at that edge; latency is 1 clock.
- Reset release coinciding with a clock edge: `out_q` either stays 0 or loads S(in); benches must not check that edge.
- Reset asserted mid-stream: `out_q` clears asynchronously; the combinational `out` keeps tracking `in`.
- No handshake, no enable; `out_q` loads every cycle.
- Key reference values:
  - 00→63, 01→7C, 09→01, 10→CA, 20→B7, 53→ED, C9→DD, FF→16.
- Bijective: all 256 outputs distinct. No fixed points: S(x)≠x for all x. No anti-fixed points: S(x)≠~x for all x.

Test Plan:
- Exhaustive sweep of in = 0x00..0xFF → `out` matches the FIPS-197 table; spot-check 00→63, 53→ED, FF→16; collected outputs form a permutation with S(x)≠x and S(x)≠~x.
- Hold rst=0, toggle clk, drive in=0x53 → `out_q`=00 throughout, `out`=ED.
- Release rst, in=0x01, one rising edge → `out_q`=7C; change in to 0x10 between edges → `out`=CA at once, `out_q` still 7C until the next edge, then CA.
- Streaming: in = 0x09, 0x20, 0xC9 on successive cycles → `out_q` = 01, B7, DD, each one cycle after its input.
- Async reset pulse between clock edges while `out_q`=DD → `out_q` goes to 00 immediately, before any clock edge; after release, the next edge reloads S(in).
- Four parallel instances on word 00 00 00 00, RotWord order → outputs 63 63 63 63; XOR of the first byte with rcon 01 gives 62 63 63 63, the AES-128 all-zero-key word w4 input.
